sys_ctrl: RTL and testbench

Command controller between the UART receiver/transmitter and the register file/ALU datapath in the UART system, running in the REF_CLK domain. It parses received command frames (RF write, RF read, ALU with operands, ALU without operands) and sequences register-file accesses, ALU operations and ALU clock gating. It returns read data and ALU results to the UART transmitter byte by byte.

---
 rtl/sys_ctrl_if.sv | 38 +++
 rtl/sys_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sys_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_if.sv
// Bus bundle between the command controller and its surroundings: the UART
// RX/TX byte streams, the register-file port and the ALU control lines.
interface sys_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [DATA_WIDTH-1:0]   RdData;
    logic                    RdData_Valid;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    OUT_Valid;
    logic                    TX_Busy;
    logic                    WrEn;
    logic                    RdEn;
    logic [ADDR_WIDTH-1:0]   Address;
    logic [DATA_WIDTH-1:0]   WrData;
    logic                    ALU_EN;
    logic [FUN_WIDTH-1:0]    ALU_FUN;
    logic                    CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;

    // Controller side
    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_Busy,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD
    );

    // UART / register file / ALU side
    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_Busy,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD
    );
endinterface

// File: rtl/sys_ctrl.sv
// Command controller: parses UART command frames, drives register-file and
// ALU strobes, gates the ALU clock and returns results to the UART TX.
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic          CLK,
    input  logic          RST,
    sys_ctrl_if.master    bus
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OPA,
        OPB,
        FUN,
        ALU_WAIT,
        TX_B0,
        TX_B1_WAIT,
        TX_B1
    } state_t;

    state_t                  state;
    logic [2*DATA_WIDTH-1:0] tx_buf;
    logic                    alu_resp;

    // Command FSM with registered strobes; TX request is raised only while the transmitter is free and held until it reports busy
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state           <= IDLE;
            tx_buf          <= '0;
            alu_resp        <= 1'b0;
            bus.WrEn        <= 1'b0;
            bus.RdEn        <= 1'b0;
            bus.Address     <= '0;
            bus.WrData      <= '0;
            bus.ALU_EN      <= 1'b0;
            bus.ALU_FUN     <= '0;
            bus.CLK_GATE_EN <= 1'b0;
            bus.TX_P_DATA   <= '0;
            bus.TX_D_VLD    <= 1'b0;
        end else begin
            bus.WrEn   <= 1'b0;
            bus.RdEn   <= 1'b0;
            bus.ALU_EN <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.RX_D_VLD) begin
                        case (bus.RX_P_DATA)
                            CMD_WR:      state <= WR_ADDR;
                            CMD_RD:      state <= RD_ADDR;
                            CMD_ALU_OP:  state <= OPA;
                            CMD_ALU_NOP: begin
                                state           <= FUN;
                                bus.CLK_GATE_EN <= 1'b1;
                            end
                            default:     state <= IDLE;
                        endcase
                    end
                end
                WR_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        state       <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (bus.RX_D_VLD) begin
                        bus.WrEn   <= 1'b1;
                        bus.WrData <= bus.RX_P_DATA;
                        state      <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        bus.RdEn    <= 1'b1;
                        bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.RdData_Valid) begin
                        tx_buf        <= {{DATA_WIDTH{1'b0}}, bus.RdData};
                        alu_resp      <= 1'b0;
                        bus.TX_P_DATA <= bus.RdData;
                        bus.TX_D_VLD  <= !bus.TX_Busy;
                        state         <= TX_B0;
                    end
                end
                OPA: begin
                    if (bus.RX_D_VLD) begin
                        bus.WrEn    <= 1'b1;
                        bus.Address <= '0;
                        bus.WrData  <= bus.RX_P_DATA;
                        state       <= OPB;
                    end
                end
                OPB: begin
                    if (bus.RX_D_VLD) begin
                        bus.WrEn        <= 1'b1;
                        bus.Address     <= ADDR_WIDTH'(1);
                        bus.WrData      <= bus.RX_P_DATA;
                        bus.CLK_GATE_EN <= 1'b1;
                        state           <= FUN;
                    end
                end
                FUN: begin
                    if (bus.RX_D_VLD) begin
                        bus.ALU_EN  <= 1'b1;
                        bus.ALU_FUN <= bus.RX_P_DATA[FUN_WIDTH-1:0];
                        state       <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    if (bus.OUT_Valid) begin
                        tx_buf          <= bus.ALU_OUT;
                        alu_resp        <= 1'b1;
                        bus.CLK_GATE_EN <= 1'b0;
                        bus.TX_P_DATA   <= bus.ALU_OUT[DATA_WIDTH-1:0];
                        bus.TX_D_VLD    <= !bus.TX_Busy;
                        state           <= TX_B0;
                    end
                end
                TX_B0: begin
                    if (bus.TX_D_VLD && bus.TX_Busy) begin
                        bus.TX_D_VLD <= 1'b0;
                        state        <= alu_resp ? TX_B1_WAIT : IDLE;
                    end else if (!bus.TX_Busy) begin
                        bus.TX_D_VLD  <= 1'b1;
                        bus.TX_P_DATA <= tx_buf[DATA_WIDTH-1:0];
                    end
                end
                TX_B1_WAIT: begin
                    if (!bus.TX_Busy) begin
                        bus.TX_D_VLD  <= 1'b1;
                        bus.TX_P_DATA <= tx_buf[2*DATA_WIDTH-1:DATA_WIDTH];
                        state         <= TX_B1;
                    end
                end
                TX_B1: begin
                    if (bus.TX_D_VLD && bus.TX_Busy) begin
                        bus.TX_D_VLD <= 1'b0;
                        state        <= IDLE;
                    end else if (!bus.TX_Busy) begin
                        bus.TX_D_VLD  <= 1'b1;
                        bus.TX_P_DATA <= tx_buf[2*DATA_WIDTH-1:DATA_WIDTH];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: commands push the expected strobe/TX events,
// a monitor pops and compares whenever the DUT emits one.
module tb_sys_ctrl;

    localparam logic [1:0] EV_WR  = 2'd0;
    localparam logic [1:0] EV_RD  = 2'd1;
    localparam logic [1:0] EV_ALU = 2'd2;
    localparam logic [1:0] EV_TX  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    logic CLK;
    logic RST;

    sys_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bus ();

    sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    ev_t exp_q[$];
    int  check_count = 0;
    int  pass_count  = 0;
    int  exp_total   = 0;
    int  obs_total   = 0;

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Global safety net against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    function automatic void push_ev(input logic [1:0] kind, input logic [3:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
        exp_total++;
    endfunction

    task automatic observe(input ev_t got);
        ev_t want;
        obs_total++;
        if (exp_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL unexpected_event: got kind=%0d addr=0x%0h data=0x%0h, required no event",
                     got.kind, got.addr, got.data);
        end else begin
            want = exp_q.pop_front();
            check_output($sformatf("event_%0d", obs_total), 32'({2'b00, got}), 32'({2'b00, want}));
        end
    endtask

    // Monitor: every strobe and every accepted TX byte is compared against the scoreboard
    always @(negedge CLK) begin
        if (RST) begin
            if (bus.WrEn) observe({EV_WR, bus.Address, bus.WrData});
            if (bus.RdEn) observe({EV_RD, bus.Address, 8'h00});
            if (bus.ALU_EN) begin
                observe({EV_ALU, 4'h0, 4'h0, bus.ALU_FUN});
                check_output("gate_at_alu_en", 32'(bus.CLK_GATE_EN), 1);
            end
            if (bus.TX_D_VLD && bus.TX_Busy) observe({EV_TX, 4'h0, bus.TX_P_DATA});
        end
    end

    // UART transmitter model: accepts a request after a random delay and stays busy for a while
    initial begin
        bus.TX_Busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST && bus.TX_D_VLD && !bus.TX_Busy) begin
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                @(posedge CLK);
                #1 bus.TX_Busy = 1'b1;
                repeat ($urandom_range(2, 5)) @(posedge CLK);
                #1 bus.TX_Busy = 1'b0;
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] b, input int gap);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        bus.RX_D_VLD  = 1'b0;
        repeat (gap) begin
            @(posedge CLK); #1;
        end
    endtask

    function automatic logic [7:0] pick_cmd();
        logic [7:0] cmds [4];
        cmds[0] = 8'hAA; cmds[1] = 8'hBB; cmds[2] = 8'hCC; cmds[3] = 8'hDD;
        return cmds[$urandom_range(0, 3)];
    endfunction

    function automatic logic [7:0] pick_noncmd();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
        return b;
    endfunction

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !bus.TX_Busy && !bus.TX_D_VLD) done = 1;
        end
        if (!done) begin
            check_count++;
            $display("[TB] FAIL %s_timeout: %0d events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge CLK); #1;
        check_output({name, "_gate_idle"}, 32'(bus.CLK_GATE_EN), 0);
    endtask

    task automatic check_reset(input string name);
        check_output({name, "_WrEn"},        32'(bus.WrEn), 0);
        check_output({name, "_RdEn"},        32'(bus.RdEn), 0);
        check_output({name, "_ALU_EN"},      32'(bus.ALU_EN), 0);
        check_output({name, "_CLK_GATE_EN"}, 32'(bus.CLK_GATE_EN), 0);
        check_output({name, "_TX_D_VLD"},    32'(bus.TX_D_VLD), 0);
        check_output({name, "_Address"},     32'(bus.Address), 0);
        check_output({name, "_WrData"},      32'(bus.WrData), 0);
        check_output({name, "_ALU_FUN"},     32'(bus.ALU_FUN), 0);
        check_output({name, "_TX_P_DATA"},   32'(bus.TX_P_DATA), 0);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        push_ev(EV_WR, addr[3:0], data);
        apply_stimulus(8'hAA, $urandom_range(0, 2));
        apply_stimulus(addr, $urandom_range(0, 2));
        apply_stimulus(data, 0);
        wait_idle("write");
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] data);
        int mode = $urandom_range(0, 2);
        push_ev(EV_RD, addr[3:0], 8'h00);
        push_ev(EV_TX, 4'h0, data);
        apply_stimulus(8'hBB, $urandom_range(0, 2));
        apply_stimulus(addr, $urandom_range(0, 2));
        if (mode == 1) apply_stimulus(pick_cmd(), $urandom_range(0, 2));
        bus.RdData       = data;
        bus.RdData_Valid = 1'b1;
        if (mode == 2) begin
            bus.RX_P_DATA = pick_cmd();
            bus.RX_D_VLD  = 1'b1;
        end
        @(posedge CLK); #1;
        bus.RdData_Valid = 1'b0;
        bus.RX_D_VLD     = 1'b0;
        @(negedge CLK);
        check_output("read_tx_latency", 32'(bus.TX_D_VLD), 1);
        wait_idle("read");
    endtask

    task automatic do_alu(input bit with_ops, input logic [7:0] opa, input logic [7:0] opb,
                          input logic [7:0] fun, input logic [15:0] res);
        if (with_ops) begin
            push_ev(EV_WR, 4'h0, opa);
            push_ev(EV_WR, 4'h1, opb);
        end
        push_ev(EV_ALU, 4'h0, {4'h0, fun[3:0]});
        push_ev(EV_TX, 4'h0, res[7:0]);
        push_ev(EV_TX, 4'h0, res[15:8]);
        if (with_ops) begin
            apply_stimulus(8'hCC, $urandom_range(0, 2));
            apply_stimulus(opa, $urandom_range(0, 2));
            apply_stimulus(opb, $urandom_range(0, 2));
        end else begin
            apply_stimulus(8'hDD, $urandom_range(0, 2));
        end
        apply_stimulus(fun, 0);
        @(negedge CLK);
        check_output("gate_alu_wait", 32'(bus.CLK_GATE_EN), 1);
        @(posedge CLK); #1;
        repeat ($urandom_range(0, 2)) apply_stimulus(pick_cmd(), 0);
        bus.ALU_OUT   = res;
        bus.OUT_Valid = 1'b1;
        @(negedge CLK);
        check_output("gate_out_valid", 32'(bus.CLK_GATE_EN), 1);
        @(posedge CLK); #1;
        bus.OUT_Valid = 1'b0;
        @(negedge CLK);
        check_output("gate_after_out_valid", 32'(bus.CLK_GATE_EN), 0);
        check_output("alu_tx_latency", 32'(bus.TX_D_VLD), 1);
        wait_idle("alu");
    endtask

    // Main stimulus: directed frames, randomized frames, then a mid-command reset
    initial begin
        bus.RX_P_DATA    = 8'h00;
        bus.RX_D_VLD     = 1'b0;
        bus.RdData       = 8'h00;
        bus.RdData_Valid = 1'b0;
        bus.ALU_OUT      = 16'h0000;
        bus.OUT_Valid    = 1'b0;
        RST = 1'b1;
        #1 RST = 1'b0;
        #3;
        check_reset("reset");
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;

        do_write(8'h02, 8'h1F);
        do_read(8'h02, 8'h1F);
        do_alu(1'b1, 8'h05, 8'h03, 8'h01, 16'h0002);
        do_alu(1'b0, 8'h00, 8'h00, 8'h00, 16'h0008);
        apply_stimulus(8'h55, 4);
        check_output("idle_junk_no_tx", 32'(bus.TX_D_VLD), 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.RdData       = 8'($urandom);
                bus.ALU_OUT      = 16'($urandom);
                bus.RdData_Valid = 1'($urandom);
                bus.OUT_Valid    = !bus.RdData_Valid;
                @(posedge CLK); #1;
                bus.RdData_Valid = 1'b0;
                bus.OUT_Valid    = 1'b0;
            end
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom), 8'($urandom));
                1: do_read(8'($urandom), 8'($urandom));
                2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
                3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom));
                default: apply_stimulus(pick_noncmd(), 3);
            endcase
        end

        apply_stimulus(8'hCC, 0);
        apply_stimulus(8'h05, 0);
        #2 RST = 1'b0;
        #1;
        check_reset("mid_cmd_reset");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        do_write(8'h07, 8'h5A);
        repeat (5) @(posedge CLK);

        check_output("event_count", obs_total, exp_total);
        check_output("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
